// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: Q8.8 sample type and default vector geometry.
package cnn_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int VEC_LEN_DEF = 121;

  typedef logic signed [DATA_W_DEF-1:0] q88_t;
endpackage

// File: rtl/flatten_buffer_bank.sv
// One VEC_LEN-deep register bank: single indexed write port, full parallel read port.
module vec_bank
  import cnn_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int VEC_LEN = VEC_LEN_DEF,
  localparam int IDX_W  = $clog2(VEC_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         widx_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  output logic signed [DATA_W-1:0] rd_vec_o [0:VEC_LEN-1]
);

  logic signed [DATA_W-1:0] mem_q [0:VEC_LEN-1];

  // Sample storage, cleared on reset and written one entry per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rd_vec_o = mem_q;

endmodule

// File: rtl/flatten_buffer.sv
// Ping-pong flatten buffer: fills one bank from a serial stream while the dense
// layer reads the other; swaps banks and pulses vec_start once a vector is complete.
module flatten_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int VEC_LEN = VEC_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] out_vec [0:VEC_LEN-1],
  output logic                     vec_start,
  input  logic                     vec_done,
  output logic                     err_len
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_e;

  wr_state_e        wr_state_q;
  rd_state_e        rd_state_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_bank_q;
  logic             s_ready_q;
  logic             vec_start_q;
  logic             err_len_q;

  logic beat;
  logic swap;
  logic bank0_we;
  logic bank1_we;
  logic signed [DATA_W-1:0] bank0_vec [0:VEC_LEN-1];
  logic signed [DATA_W-1:0] bank1_vec [0:VEC_LEN-1];

  assign beat = s_valid && s_ready_q;
  // A full vector hands over as soon as the reader is free, including the edge it frees up.
  assign swap = (wr_state_q == W_FULL) && ((rd_state_q == R_IDLE) || vec_done);

  assign bank0_we = beat && !wr_bank_q;
  assign bank1_we = beat &&  wr_bank_q;

  vec_bank #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bank0_we),
    .widx_i   (wr_idx_q),
    .wdata_i  (s_data),
    .rd_vec_o (bank0_vec)
  );

  vec_bank #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bank1_we),
    .widx_i   (wr_idx_q),
    .wdata_i  (s_data),
    .rd_vec_o (bank1_vec)
  );

  // Writer and reader FSMs with their registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= W_FILL;
      rd_state_q  <= R_IDLE;
      wr_idx_q    <= {IDX_W{1'b0}};
      wr_bank_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      vec_start_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      vec_start_q <= 1'b0;

      case (wr_state_q)
        W_FILL: begin
          s_ready_q <= 1'b1;
          if (beat) begin
            if (wr_idx_q == LAST_IDX) begin
              wr_state_q <= W_FULL;
              wr_idx_q   <= {IDX_W{1'b0}};
              s_ready_q  <= 1'b0;
              if (!s_last) begin
                err_len_q <= 1'b1;
              end
            end else if (s_last) begin
              wr_idx_q  <= {IDX_W{1'b0}};
              err_len_q <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_ONE;
            end
          end
        end
        W_FULL: begin
          if (swap) begin
            wr_state_q  <= W_FILL;
            wr_bank_q   <= ~wr_bank_q;
            s_ready_q   <= 1'b1;
            vec_start_q <= 1'b1;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          wr_state_q <= W_FILL;
          s_ready_q  <= 1'b0;
        end
      endcase

      case (rd_state_q)
        R_IDLE: begin
          if (swap) begin
            rd_state_q <= R_BUSY;
          end
        end
        R_BUSY: begin
          if (vec_done && !swap) begin
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Read bank is always the one the writer is not filling.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      out_vec[i] = wr_bank_q ? bank0_vec[i] : bank1_vec[i];
    end
  end

  assign s_ready   = s_ready_q;
  assign vec_start = vec_start_q;
  assign err_len   = err_len_q;

endmodule

// File: doc/flatten_buffer.md
# flatten_buffer

Ping-pong vector buffer between the conv/pool stage and the dense layer. Collects a serial stream of Q8.8 feature-map values (one per beat, valid/ready) into a VEC_LEN-entry vector. Presents the full vector as a parallel, stable array to the dense neurons and issues their one-cycle `start`. While the neurons compute on one bank, the next image fills the other bank.

## Interface
- `DATA_W`, 16: sample width, signed Q8.8.
- `VEC_LEN`, 121: vector length (11x11 flattened, row-major).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: upstream sample valid.
- `s_data` in DATA_W signed: upstream sample.
- `s_last` in 1: marks final sample of an image.
- `s_ready` out 1: buffer accepts a beat this cycle.
- `out_vec` out DATA_W signed x [0:VEC_LEN-1]: read-bank contents, feeds dense `in_vec`.
- `vec_start` out 1: one-cycle pulse, feeds dense `start`.
- `vec_done` in 1: dense-layer `done` pulse (AND of all neuron dones, external).
- `err_len` out 1: sticky framing error.

## Operation
- Two banks, each VEC_LEN x DATA_W. `wr_bank` and `rd_bank` are 1-bit selects; `rd_bank` always equals `~wr_bank`. `out_vec` = bank[`rd_bank`], driven combinationally from registers.
- Writer FSM:
  - In FILL:
    - `s_ready`=1.
    - Each beat (`s_valid && s_ready`) writes bank[`wr_bank`][`wr_idx`] and increments `wr_idx`.
    - A beat at `wr_idx`==VEC_LEN-1 moves the writer to FULL and wraps `wr_idx` to 0.
  - In FULL:
    - `s_ready`=0.
    - Waits for the reader to be IDLE, or to go IDLE in the same cycle.
  - Framing rules:
    - `s_last` on a beat with `wr_idx`<VEC_LEN-1: the partial image is discarded, `wr_idx`<=0, the writer stays in FILL, and `err_len`<=1.
    - No `s_last` on the beat at VEC_LEN-1: the vector is still treated as complete (length-driven) and `err_len`<=1.
- Reader FSM:
  - IDLE to BUSY on swap.
  - BUSY to IDLE when `vec_done` is sampled high.
- Swap: occurs at the clock edge where the writer is FULL and (reader IDLE, or reader BUSY with `vec_done`=1). On that edge:
  - `wr_bank` toggles.
  - The reader goes to BUSY.
  - The writer goes to FILL.
  - `vec_start`<=1 for exactly one cycle.
- `vec_done` while the reader is IDLE is ignored.
- No ReLU or scaling; samples are stored bit-exact.

## Timing
- Reset values:
  - `s_ready`=0. The writer resets to FILL, and `s_ready` goes to 1 at the first edge after reset release (`s_ready` is registered).
  - `vec_start`=0, `err_len`=0, both banks all-zero, so `out_vec`=0.
  - `wr_bank`=0, `wr_idx`=0, reader IDLE.
- Final beat accepted at edge N with reader IDLE:
  - Writer is FULL in cycle N..N+1.
  - Swap at edge N+1.
  - `vec_start` is high in cycle N+1..N+2.
  - `out_vec` is the new image from edge N+1.
  - `s_ready` is high again from edge N+1, giving exactly one stall cycle.
- `out_vec` is held stable from the swap edge until the edge that samples `vec_done`, because the neurons index `in_vec` across many cycles.
- Back-pressure: if the reader is BUSY, `s_ready` stays low until the edge sampling `vec_done`. The swap happens on that same edge, with no extra idle cycle.
- Throughput: one sample per cycle, plus one stall cycle per image when the dense layer is faster than the stream.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight image is lost and no `vec_start` is issued.
- `err_len` is cleared only by reset.

## Structure
- Shared package `cnn_pkg`: `DATA_W`, `VEC_LEN` defaults, and a Q8.8 sample typedef. Writer and reader state enums stay local.
- One sub-module is natural: `vec_bank` (a single VEC_LEN register bank with write enable/index and a parallel read port), instantiated twice. Control logic stays in `flatten_buffer`.

## Test plan
- Reset, then stream samples 0x0001..0x0079 (121 beats, `s_last` on the last), with `vec_done` held low: one `vec_start` pulse 1 cycle after the last beat; `out_vec[0]`=0x0001, `out_vec[120]`=0x0079; `s_ready` high again.
- While BUSY, stream a second image 0x1000+i: `s_ready` drops after its 121st beat and `out_vec` is unchanged. Pulse `vec_done`: swap on that edge, `vec_start` the next cycle, `out_vec[5]`=0x1005.
- `s_last` at beat 50: `err_len`=1, no `vec_start`. Then a full 121-beat image produces a normal `vec_start` with correct contents.
- 121 beats without `s_last`: `err_len`=1, `vec_start` still pulses, data correct.
- Random `s_valid` gaps (30% idle) plus a `vec_done` asserted while the reader is IDLE: contents are exact, the stray `vec_done` is ignored, and there is exactly one `vec_start` per image.
- Assert `rst_n` low mid-image (beat 60) and while BUSY: all outputs return to reset values; after release, a fresh image yields correct `out_vec`.
